// File: rtl/interleaver_bank_scheduler.sv
// Ping-pong bank scheduler for the turbo interleaver RAM pair.
// Assigns each incoming block to a free bank, generates linear write and
// read indices, and drains banks strictly in the order they were filled.
module interleaver_bank_scheduler #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int AW      = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blk_start,
  input  logic          blk_size,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  input  logic          out_ready,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          rd_size,
  output logic          rd_first,
  output logic          rd_last,
  output logic          blk_done,
  output logic [1:0]    bank_full,
  output logic          overflow_err
);

  typedef enum logic [1:0] {B_FREE = 2'd0, B_FILL = 2'd1, B_FULL = 2'd2, B_DRAIN = 2'd3} bank_state_t;
  typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_DRAIN = 1'b1} rd_state_t;

  // Terminal index of a block of the given size.
  function automatic logic [AW-1:0] k_last(input logic size);
    k_last = size ? AW'(K_LARGE - 1) : AW'(K_SMALL - 1);
  endfunction

  wr_state_t   wr_state_r, wr_state_s;
  rd_state_t   rd_state_r, rd_state_s;
  bank_state_t bank_st_r [2];
  bank_state_t bank_st_s [2];
  logic [1:0]    size_r, size_s;
  logic          wr_bank_r, wr_bank_s;
  logic [AW-1:0] wr_addr_r, wr_addr_s;
  logic          rd_bank_r, rd_bank_s;
  logic [AW-1:0] rd_addr_r, rd_addr_s;
  logic          rd_size_r, rd_size_s;
  logic          next_rd_r, next_rd_s;
  logic          blk_done_r, blk_done_s;
  logic          ovf_r, ovf_s;
  logic          wr_fire_s, rd_fire_s, wr_term_s, rd_term_s, claim_s, free_any_s;

  assign wr_fire_s  = in_valid & (wr_state_r == WR_FILL);
  assign rd_fire_s  = out_ready & (rd_state_r == RD_DRAIN);
  assign wr_term_s  = wr_fire_s & (wr_addr_r == k_last(size_r[wr_bank_r]));
  assign rd_term_s  = rd_fire_s & (rd_addr_r == k_last(rd_size_r));
  assign free_any_s = (bank_st_r[0] == B_FREE) | (bank_st_r[1] == B_FREE);
  assign claim_s    = (bank_st_r[0] == B_FREE) ? 1'b0 : 1'b1;

  // Next-state logic for writer, reader, bank states and index counters.
  always_comb begin
    wr_state_s   = wr_state_r;
    rd_state_s   = rd_state_r;
    bank_st_s    = bank_st_r;
    size_s       = size_r;
    wr_bank_s    = wr_bank_r;
    wr_addr_s    = wr_addr_r;
    rd_bank_s    = rd_bank_r;
    rd_addr_s    = rd_addr_r;
    rd_size_s    = rd_size_r;
    next_rd_s    = next_rd_r;
    blk_done_s   = 1'b0;
    ovf_s        = 1'b0;

    // Reader first so a completing write can override the fill-order bit.
    case (rd_state_r)
      RD_IDLE: begin
        if (bank_st_r[next_rd_r] == B_FULL) begin
          rd_state_s           = RD_DRAIN;
          rd_bank_s            = next_rd_r;
          rd_size_s            = size_r[next_rd_r];
          rd_addr_s            = {AW{1'b0}};
          bank_st_s[next_rd_r] = B_DRAIN;
        end else begin
          rd_state_s = RD_IDLE;
        end
      end
      RD_DRAIN: begin
        if (rd_term_s) begin
          bank_st_s[rd_bank_r] = B_FREE;
          next_rd_s            = ~rd_bank_r;
          rd_state_s           = RD_IDLE;
          rd_addr_s            = {AW{1'b0}};
          blk_done_s           = 1'b1;
        end else if (rd_fire_s) begin
          rd_addr_s = rd_addr_r + AW'(1);
        end else begin
          rd_addr_s = rd_addr_r;
        end
      end
      default: rd_state_s = RD_IDLE;
    endcase

    case (wr_state_r)
      WR_IDLE: begin
        if (blk_start && free_any_s) begin
          wr_bank_s          = claim_s;
          size_s[claim_s]    = blk_size;
          wr_addr_s          = {AW{1'b0}};
          bank_st_s[claim_s] = B_FILL;
          wr_state_s         = WR_FILL;
        end else if (blk_start) begin
          ovf_s = 1'b1;
        end else begin
          wr_state_s = WR_IDLE;
        end
      end
      WR_FILL: begin
        ovf_s = blk_start;
        if (wr_term_s) begin
          bank_st_s[wr_bank_r] = B_FULL;
          wr_addr_s            = {AW{1'b0}};
          wr_state_s           = WR_IDLE;
          // Only record this bank as next if the other is not already queued.
          if (bank_st_r[~wr_bank_r] != B_FULL) begin
            next_rd_s = wr_bank_r;
          end else begin
            next_rd_s = next_rd_r;
          end
        end else if (wr_fire_s) begin
          wr_addr_s = wr_addr_r + AW'(1);
        end else begin
          wr_addr_s = wr_addr_r;
        end
      end
      default: wr_state_s = WR_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_r <= WR_IDLE;
      rd_state_r <= RD_IDLE;
      for (int i = 0; i < 2; i++) bank_st_r[i] <= B_FREE;
      size_r     <= 2'b00;
      wr_bank_r  <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      rd_bank_r  <= 1'b0;
      rd_addr_r  <= {AW{1'b0}};
      rd_size_r  <= 1'b0;
      next_rd_r  <= 1'b0;
      blk_done_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
      bank_st_r  <= bank_st_s;
      size_r     <= size_s;
      wr_bank_r  <= wr_bank_s;
      wr_addr_r  <= wr_addr_s;
      rd_bank_r  <= rd_bank_s;
      rd_addr_r  <= rd_addr_s;
      rd_size_r  <= rd_size_s;
      next_rd_r  <= next_rd_s;
      blk_done_r <= blk_done_s;
      ovf_r      <= ovf_s;
    end
  end

  assign in_ready     = (wr_state_r == WR_FILL);
  assign wr_en        = wr_fire_s;
  assign wr_bank      = wr_bank_r;
  assign wr_addr      = wr_addr_r;
  assign rd_en        = rd_fire_s;
  assign rd_bank      = rd_bank_r;
  assign rd_addr      = rd_addr_r;
  assign rd_size      = rd_size_r;
  assign rd_first     = rd_fire_s & (rd_addr_r == {AW{1'b0}});
  assign rd_last      = rd_term_s;
  assign blk_done     = blk_done_r;
  assign overflow_err = ovf_r;
  assign bank_full    = {(bank_st_r[1] == B_FULL) | (bank_st_r[1] == B_DRAIN),
                         (bank_st_r[0] == B_FULL) | (bank_st_r[0] == B_DRAIN)};

endmodule

// File: tb/tb_interleaver_bank_scheduler.sv
// Directed bench for interleaver_bank_scheduler with a queue scoreboard:
// each accepted block pushes its expected bank/size to the write and read
// queues; a negedge monitor pops and checks every strobe against them.
module tb_interleaver_bank_scheduler;
  localparam int KS = 1056;
  localparam int KL = 6144;
  localparam int AW = 13;

  logic clk = 1'b0, reset = 1'b1;
  logic blk_start = 1'b0, blk_size = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, wr_en, wr_bank, rd_en, rd_bank, rd_size, rd_first, rd_last;
  logic blk_done, overflow_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0] bank_full;

  interleaver_bank_scheduler #(.K_SMALL(KS), .K_LARGE(KL), .AW(AW)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .blk_size(blk_size),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .out_ready(out_ready), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_first(rd_first), .rd_last(rd_last),
    .blk_done(blk_done), .bank_full(bank_full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic bank; logic size; } blk_t;
  blk_t wr_q[$];
  blk_t rd_q[$];
  int n_checks = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic done_due = 1'b0;

  function automatic int klen(input logic s);
    return s ? KL : KS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("blk_done", {31'd0, blk_done}, {31'd0, done_due});
      if (blk_done) done_cnt++;
      done_due = 1'b0;
      if (!in_valid)  check("wr_gate", {31'd0, wr_en}, 32'd0);
      if (!out_ready) check("rd_gate", {31'd0, rd_en}, 32'd0);
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_q.size()), 32'd1);
        else begin
          check("wr_bank", {31'd0, wr_bank}, {31'd0, wr_q[0].bank});
          check("wr_addr", {19'd0, wr_addr}, 32'(wr_cnt));
          if (wr_cnt == klen(wr_q[0].size) - 1) begin
            void'(wr_q.pop_front());
            wr_cnt = 0;
          end else wr_cnt++;
        end
      end
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_q.size()), 32'd1);
        else begin
          check("rd_bank", {31'd0, rd_bank}, {31'd0, rd_q[0].bank});
          check("rd_size", {31'd0, rd_size}, {31'd0, rd_q[0].size});
          check("rd_addr", {19'd0, rd_addr}, 32'(rd_cnt));
          check("rd_first", {31'd0, rd_first}, (rd_cnt == 0) ? 32'd1 : 32'd0);
          check("rd_last", {31'd0, rd_last}, (rd_cnt == klen(rd_q[0].size) - 1) ? 32'd1 : 32'd0);
          if (rd_cnt == klen(rd_q[0].size) - 1) begin
            void'(rd_q.pop_front());
            rd_cnt = 0;
            done_due = 1'b1;
          end else rd_cnt++;
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_bank"}, {31'd0, wr_bank}, 32'd0);
    check({tag, "_wr_addr"}, {19'd0, wr_addr}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    check({tag, "_rd_bank"}, {31'd0, rd_bank}, 32'd0);
    check({tag, "_rd_addr"}, {19'd0, rd_addr}, 32'd0);
    check({tag, "_rd_size"}, {31'd0, rd_size}, 32'd0);
    check({tag, "_rd_first_last"}, {30'd0, rd_first, rd_last}, 32'd0);
    check({tag, "_blk_done"}, {31'd0, blk_done}, 32'd0);
    check({tag, "_bank_full"}, {30'd0, bank_full}, 32'd0);
    check({tag, "_overflow"}, {31'd0, overflow_err}, 32'd0);
  endtask

  task automatic start_block(input logic s, input logic exp_bank);
    blk_t e;
    e.bank = exp_bank;
    e.size = s;
    wr_q.push_back(e);
    rd_q.push_back(e);
    @(posedge clk); #1;
    blk_start = 1'b1; blk_size = s;
    @(posedge clk); #1;
    blk_start = 1'b0; blk_size = 1'b0;
  endtask

  task automatic reject_block(input string tag);
    @(posedge clk); #1;
    blk_start = 1'b1; blk_size = 1'b1;
    @(posedge clk); #1;
    blk_start = 1'b0; blk_size = 1'b0;
    @(negedge clk);
    check({tag, "_ovf_pulse"}, {31'd0, overflow_err}, 32'd1);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ovf_end"}, {31'd0, overflow_err}, 32'd0);
  endtask

  // Feed n accepted bits; toggle=1 alternates in_valid every cycle.
  task automatic feed(input int n, input bit toggle);
    int strobes = 0;
    int cyc = 0;
    logic phase = 1'b1;
    while (strobes < n && cyc < 4 * n) begin
      in_valid = toggle ? phase : 1'b1;
      @(negedge clk);
      if (in_valid) check("in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (in_valid) strobes++;
      phase = ~phase;
      cyc++;
    end
    in_valid = 1'b0;
    check("feed_count", 32'(strobes), 32'(n));
  endtask

  task automatic wait_done(input int target, input int bound, input bit toggle);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      if (done_cnt >= target) break;
    end
    check("done_wait", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int base;
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // Single small block with the consumer always ready.
    out_ready = 1'b1;
    start_block(1'b0, 1'b0);
    feed(KS, 1'b0);
    @(negedge clk);
    check("small_bank_full", {30'd0, bank_full}, 32'd1);
    wait_done(1, KS + 20, 1'b0);
    @(negedge clk);
    check("small_free", {30'd0, bank_full}, 32'd0);

    // Two large blocks with the consumer stalled, then a rejected third.
    out_ready = 1'b0;
    start_block(1'b1, 1'b0);
    feed(KL, 1'b0);
    start_block(1'b1, 1'b1);
    feed(KL, 1'b0);
    @(negedge clk);
    check("pp_bank_full", {30'd0, bank_full}, 32'd3);
    reject_block("pp");
    out_ready = 1'b1;
    wait_done(3, 2 * KL + 40, 1'b0);

    // Fill order large then small, drained in that order.
    out_ready = 1'b0;
    start_block(1'b1, 1'b0);
    feed(KL, 1'b0);
    start_block(1'b0, 1'b1);
    feed(KS, 1'b0);
    out_ready = 1'b1;
    wait_done(5, KL + KS + 40, 1'b0);
    @(negedge clk);
    check("order_free", {30'd0, bank_full}, 32'd0);

    // Backpressure on both sides.
    out_ready = 1'b0;
    start_block(1'b0, 1'b0);
    feed(KS, 1'b1);
    wait_done(6, 2 * KS + 40, 1'b1);
    out_ready = 1'b1;

    // Reset in the middle of a drain.
    start_block(1'b0, 1'b0);
    feed(KS, 1'b0);
    for (int i = 0; i < KS; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 13'd500) break;
    end
    check("mid_rd_addr", {19'd0, rd_addr}, 32'd500);
    #1 reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    wr_q.delete(); rd_q.delete();
    wr_cnt = 0; rd_cnt = 0; done_due = 1'b0;
    @(negedge clk); reset = 1'b0;
    base = done_cnt;
    start_block(1'b0, 1'b0);
    feed(KS, 1'b0);
    wait_done(base + 1, KS + 20, 1'b0);

    // Large block written into bank1 while bank0 drains.
    base = done_cnt;
    out_ready = 1'b0;
    start_block(1'b0, 1'b0);
    feed(KS, 1'b0);
    out_ready = 1'b1;
    start_block(1'b1, 1'b1);
    feed(KL, 1'b0);
    check("conc_first_done", 32'(done_cnt), 32'(base + 1));
    @(negedge clk);
    check("conc_bank_full", {30'd0, bank_full}, 32'd2);
    wait_done(base + 2, KL + 40, 1'b0);
    @(negedge clk);
    check("conc_free", {30'd0, bank_full}, 32'd0);
    check("queues_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
